lemming_tracker: RTL and testbench



---
 rtl/lemming_tracker_if.sv | 29 ++
 rtl/lemming_tracker.sv | 125 ++++++++++++
 tb/tb_lemming_tracker.sv | 231 +++++++++++++++++++++++
 3 files changed

// File: rtl/lemming_tracker_if.sv
// Status/result bundle between the lemming behaviour FSM (master) and its tracker (slave).
interface lemming_tracker_if #(
    parameter int POS_W = 8,
    parameter int CNT_W = 16
);
  logic             walk_left;
  logic             walk_right;
  logic             aaah;
  logic             digging;
  logic [POS_W-1:0] pos;
  logic [CNT_W-1:0] depth;
  logic [7:0]       fall_len;
  logic [7:0]       max_fall;
  logic [CNT_W-1:0] turns;
  logic             fall_done;
  logic             dead;
  logic             proto_err;
  logic             cons_err;

  modport master (
    output walk_left, walk_right, aaah, digging,
    input  pos, depth, fall_len, max_fall, turns, fall_done, dead, proto_err, cons_err
  );

  modport slave (
    input  walk_left, walk_right, aaah, digging,
    output pos, depth, fall_len, max_fall, turns, fall_done, dead, proto_err, cons_err
  );
endinterface

// File: rtl/lemming_tracker.sv
// Monitors the lemming FSM status outputs: position, depth, fall stats, turns, death and splat-rule checks.
// All outputs registered (1-cycle latency); no backpressure, one status sample consumed per clock.
module lemming_tracker #(
    parameter int POS_W     = 8,
    parameter int POS_INIT  = 128,
    parameter int CNT_W     = 16,
    parameter int SPLAT_LEN = 21
) (
    input  logic                    clk,
    input  logic                    areset,
    lemming_tracker_if.slave        trk
);
  typedef enum logic [0:0] {ST_ALIVE, ST_DEAD} state_t;

  localparam logic [7:0] SPLAT_L = 8'(SPLAT_LEN);

  state_t           state_q, state_d;
  logic [POS_W-1:0] pos_q, pos_d;
  logic [CNT_W-1:0] depth_q, depth_d;
  logic [CNT_W-1:0] turns_q, turns_d;
  logic [7:0]       fall_len_q, fall_len_d;
  logic [7:0]       max_fall_q, max_fall_d;
  logic             last_left_q, last_left_d;
  logic             prev_aaah_q, prev_aaah_d;
  logic             fall_done_q, fall_done_d;
  logic             proto_err_q, proto_err_d;
  logic             cons_err_q, cons_err_d;

  logic [2:0] n_hi;
  logic       is_ill, is_none, is_wl, is_wr, is_fall, is_dig, fall_end;

  always_comb begin
    n_hi    = 3'(trk.walk_left) + 3'(trk.walk_right) + 3'(trk.aaah) + 3'(trk.digging);
    is_ill  = (n_hi > 3'd1);
    is_none = (n_hi == 3'd0);
    is_wl   = trk.walk_left  && !is_ill;
    is_wr   = trk.walk_right && !is_ill;
    is_fall = trk.aaah       && !is_ill;
    is_dig  = trk.digging    && !is_ill;
    // An ILLEGAL sample never terminates a fall; prev_aaah is held across it.
    fall_end = prev_aaah_q && !is_fall && !is_ill;
  end

  always_comb begin
    state_d     = state_q;
    pos_d       = pos_q;
    depth_d     = depth_q;
    turns_d     = turns_q;
    fall_len_d  = fall_len_q;
    max_fall_d  = max_fall_q;
    last_left_d = last_left_q;
    prev_aaah_d = prev_aaah_q;
    fall_done_d = 1'b0;
    proto_err_d = proto_err_q | is_ill;
    cons_err_d  = cons_err_q;

    if (state_q == ST_ALIVE && !is_ill) begin
      if (is_wl) begin
        pos_d       = (pos_q == '0) ? pos_q : pos_q - 1'b1;
        last_left_d = 1'b1;
        if (!last_left_q && turns_q != '1) turns_d = turns_q + 1'b1;
      end
      if (is_wr) begin
        pos_d       = (pos_q == '1) ? pos_q : pos_q + 1'b1;
        last_left_d = 1'b0;
        if (last_left_q && turns_q != '1) turns_d = turns_q + 1'b1;
      end
      if ((is_fall || is_dig) && depth_q != '1) depth_d = depth_q + 1'b1;
      if (is_fall) begin
        if (!prev_aaah_q)             fall_len_d = 8'd1;
        else if (fall_len_q != 8'hFF) fall_len_d = fall_len_q + 8'd1;
      end
      prev_aaah_d = is_fall;

      if (fall_end) begin
        fall_done_d = 1'b1;
        if (fall_len_q > max_fall_q) max_fall_d = fall_len_q;
        if ((is_none && fall_len_q < SPLAT_L) || (!is_none && fall_len_q >= SPLAT_L))
          cons_err_d = 1'b1;
      end
      if (is_none) begin
        state_d = ST_DEAD;
        if (!prev_aaah_q) cons_err_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge areset) begin
    if (areset) begin
      state_q     <= ST_ALIVE;
      pos_q       <= POS_W'(POS_INIT);
      depth_q     <= '0;
      turns_q     <= '0;
      fall_len_q  <= '0;
      max_fall_q  <= '0;
      last_left_q <= 1'b1;
      prev_aaah_q <= 1'b0;
      fall_done_q <= 1'b0;
      proto_err_q <= 1'b0;
      cons_err_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      pos_q       <= pos_d;
      depth_q     <= depth_d;
      turns_q     <= turns_d;
      fall_len_q  <= fall_len_d;
      max_fall_q  <= max_fall_d;
      last_left_q <= last_left_d;
      prev_aaah_q <= prev_aaah_d;
      fall_done_q <= fall_done_d;
      proto_err_q <= proto_err_d;
      cons_err_q  <= cons_err_d;
    end
  end

  assign trk.pos       = pos_q;
  assign trk.depth     = depth_q;
  assign trk.turns     = turns_q;
  assign trk.fall_len  = fall_len_q;
  assign trk.max_fall  = max_fall_q;
  assign trk.fall_done = fall_done_q;
  assign trk.dead      = (state_q == ST_DEAD);
  assign trk.proto_err = proto_err_q;
  assign trk.cons_err  = cons_err_q;
endmodule

// File: tb/tb_lemming_tracker.sv
// Randomized + directed bench for lemming_tracker against a run-length based reference model.
module tb_lemming_tracker;
  localparam int C_WL = 0, C_WR = 1, C_FALL = 2, C_DIG = 3, C_NONE = 4, C_ILL = 5;
  localparam int SPLAT = 21;

  logic clk = 1'b0;
  logic areset = 1'b1;
  always #5 clk = ~clk;

  lemming_tracker_if #(.POS_W(8), .CNT_W(16)) bus ();

  lemming_tracker #(.POS_W(8), .POS_INIT(128), .CNT_W(16), .SPLAT_LEN(SPLAT)) dut (
    .clk    (clk),
    .areset (areset),
    .trk    (bus)
  );

  int n_chk  = 0;
  int n_pass = 0;

  // Reference state: plain integers, fall tracked as an unbounded run length.
  int m_pos, m_depth, m_turns, m_run, m_fall_len, m_max;
  bit m_left, m_fd, m_dead, m_perr, m_cerr;

  task automatic chk(input string tag, input int obs, input int exp);
    n_chk++;
    if (obs == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
  endtask

  function automatic int imin(input int a, input int b);
    return (a < b) ? a : b;
  endfunction

  task automatic model_reset();
    m_pos = 128; m_depth = 0; m_turns = 0; m_run = 0; m_fall_len = 0; m_max = 0;
    m_left = 1'b1; m_fd = 1'b0; m_dead = 1'b0; m_perr = 1'b0; m_cerr = 1'b0;
  endtask

  task automatic model_step(input int c);
    bit was_falling;
    m_fd = 1'b0;
    if (c == C_ILL) begin
      m_perr = 1'b1;
      return;
    end
    if (m_dead) return;
    was_falling = (m_run > 0);
    if (c == C_WL) begin
      m_pos = (m_pos > 0) ? m_pos - 1 : 0;
      if (!m_left) m_turns++;
      m_left = 1'b1;
    end
    if (c == C_WR) begin
      m_pos = (m_pos < 255) ? m_pos + 1 : 255;
      if (m_left) m_turns++;
      m_left = 1'b0;
    end
    if (c == C_FALL || c == C_DIG) m_depth++;
    if (c == C_FALL) begin
      m_run++;
      m_fall_len = imin(m_run, 255);
    end else if (was_falling) begin
      m_fd  = 1'b1;
      m_max = (m_fall_len > m_max) ? m_fall_len : m_max;
      if ((c == C_NONE) != (m_run >= SPLAT)) m_cerr = 1'b1;
      m_run = 0;
    end
    if (c == C_NONE) begin
      m_dead = 1'b1;
      if (!was_falling) m_cerr = 1'b1;
    end
  endtask

  task automatic check_all();
    chk("pos",       int'(bus.pos),       m_pos);
    chk("depth",     int'(bus.depth),     imin(m_depth, 65535));
    chk("turns",     int'(bus.turns),     imin(m_turns, 65535));
    chk("fall_len",  int'(bus.fall_len),  m_fall_len);
    chk("max_fall",  int'(bus.max_fall),  m_max);
    chk("fall_done", int'(bus.fall_done), int'(m_fd));
    chk("dead",      int'(bus.dead),      int'(m_dead));
    chk("proto_err", int'(bus.proto_err), int'(m_perr));
    chk("cons_err",  int'(bus.cons_err),  int'(m_cerr));
  endtask

  task automatic drive(input int c);
    logic [3:0] v;
    case (c)
      C_WL:    v = 4'b1000;
      C_WR:    v = 4'b0100;
      C_FALL:  v = 4'b0010;
      C_DIG:   v = 4'b0001;
      C_NONE:  v = 4'b0000;
      default: begin
        v = 4'($urandom_range(3, 15));
        while (v == 4'b0100 || v == 4'b1000 || v == 4'b0010 || v == 4'b0001 || v == 4'b0000)
          v = 4'($urandom_range(3, 15));
      end
    endcase
    {bus.walk_left, bus.walk_right, bus.aaah, bus.digging} = v;
  endtask

  // Called at a negedge; returns at the following negedge with outputs checked.
  task automatic step(input int c);
    drive(c);
    model_step(c);
    @(posedge clk);
    @(negedge clk);
    check_all();
  endtask

  task automatic steps(input int c, input int n);
    for (int i = 0; i < n; i++) step(c);
  endtask

  task automatic do_reset();
    areset = 1'b1;
    model_reset();
    #1;
    check_all();
    @(posedge clk);
    @(negedge clk);
    areset = 1'b0;
  endtask

  int fd_seen;

  initial begin
    drive(C_WL);
    model_reset();
    @(negedge clk);
    do_reset();

    // 1: walks and a single reversal
    steps(C_WL, 5);
    steps(C_WR, 3);
    chk("t1_pos", int'(bus.pos), 126);
    chk("t1_turns", int'(bus.turns), 1);

    // 2: short fall landing on a walk
    do_reset();
    step(C_WL);
    steps(C_FALL, 4);
    step(C_WL);
    chk("t2_fall_done", int'(bus.fall_done), 1);
    chk("t2_max_fall", int'(bus.max_fall), 4);
    chk("t2_depth", int'(bus.depth), 4);
    step(C_WL);
    chk("t2_fd_once", int'(bus.fall_done), 0);

    // 3: legal splat, then frozen
    do_reset();
    steps(C_FALL, 21);
    step(C_NONE);
    chk("t3_dead", int'(bus.dead), 1);
    chk("t3_cons", int'(bus.cons_err), 0);
    steps(C_WR, 10);
    chk("t3_pos_frozen", int'(bus.pos), 128);

    // 4: short fall death and survived long fall
    do_reset();
    steps(C_FALL, 20);
    step(C_NONE);
    chk("t4a_cons", int'(bus.cons_err), 1);
    do_reset();
    steps(C_FALL, 22);
    step(C_WR);
    chk("t4b_cons", int'(bus.cons_err), 1);
    chk("t4b_dead", int'(bus.dead), 0);

    // 5: illegal combination, then saturating fall length
    do_reset();
    drive(C_WL);
    bus.aaah = 1'b1;
    model_step(C_ILL);
    @(posedge clk);
    @(negedge clk);
    check_all();
    chk("t5_pos", int'(bus.pos), 128);
    steps(C_FALL, 260);
    chk("t5_fall_sat", int'(bus.fall_len), 255);

    // 6: reset mid-fall, then death without a fall
    do_reset();
    fd_seen = 0;
    for (int i = 0; i < 10; i++) begin
      step(C_FALL);
      fd_seen += int'(bus.fall_done);
    end
    do_reset();
    fd_seen += int'(bus.fall_done);
    chk("t6_no_fd", fd_seen, 0);
    chk("t6_fall_len", int'(bus.fall_len), 0);
    steps(C_DIG, 3);
    step(C_NONE);
    chk("t6_cons", int'(bus.cons_err), 1);

    // Position saturation at 0 followed by a reversal
    do_reset();
    steps(C_WL, 130);
    chk("sat_pos0", int'(bus.pos), 0);
    step(C_WR);
    chk("sat_turn", int'(bus.turns), 1);

    // Randomized bursts
    do_reset();
    for (int k = 0; k < 600; k++) begin
      int r, c, len;
      r = $urandom_range(0, 99);
      if      (r < 28) c = C_WL;
      else if (r < 56) c = C_WR;
      else if (r < 80) c = C_FALL;
      else if (r < 93) c = C_DIG;
      else if (r < 97) c = C_ILL;
      else             c = C_NONE;
      len = (c == C_FALL) ? $urandom_range(1, 30) : (c == C_NONE) ? 1 : $urandom_range(1, 4);
      steps(c, len);
      if ((m_dead && $urandom_range(0, 3) == 0) || $urandom_range(0, 99) == 0) do_reset();
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #3000000;
    $display("FAIL timeout: got 0 expected 1");
    $fatal(1);
  end
endmodule
